// File: rtl/div_round_up_seq.sv
// Multi-cycle unsigned ceiling divider (restoring shift-subtract) with valid/ready handshakes.
// Optional remainder output port enabled by defining DIV_ROUND_UP_SEQ_REMAINDER_EN.
`timescale 1ns/1ps
module div_round_up_seq #(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
`ifdef DIV_ROUND_UP_SEQ_REMAINDER_EN
  output logic [WIDTH-1:0] remainder,
`endif
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;

  state_t           state, next_state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dividend_reg, divisor_reg, work;
  logic [WIDTH:0]   rem, rem_shift, rem_diff;
  logic             fits, accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = (divisor != '0) ? CALC : DONE;
      end
      CALC:  if (count == CW'(WIDTH)) next_state = ROUND;
      ROUND: next_state = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign accept    = in_valid && in_ready;
  assign rem_shift = {rem[WIDTH-1:0], work[WIDTH-1]};
  assign fits      = rem_shift >= {1'b0, divisor_reg};
  assign rem_diff  = rem_shift - {1'b0, divisor_reg};

  // CALC step 0 loads the working register; steps 1..WIDTH each retire one quotient bit, MSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dividend_reg <= '0;
      divisor_reg  <= '0;
      work         <= '0;
      rem          <= '0;
      count        <= '0;
      quotient     <= '0;
      div_by_zero  <= 1'b0;
    end else if (accept) begin
      dividend_reg <= dividend;
      divisor_reg  <= divisor;
      work         <= '0;
      rem          <= '0;
      count        <= '0;
      if (divisor == '0) begin
        quotient    <= '1;
        div_by_zero <= 1'b1;
      end else begin
        quotient    <= '0;
        div_by_zero <= 1'b0;
      end
    end else if (state == CALC) begin
      count <= count + 1'b1;
      if (count == '0) begin
        work <= dividend_reg;
      end else begin
        work <= {work[WIDTH-2:0], fits};
        rem  <= fits ? rem_diff : rem_shift;
      end
    end else if (state == ROUND) begin
      // ceil(a/b) <= a for b >= 1, so this increment cannot overflow.
      quotient <= work + {{(WIDTH-1){1'b0}}, |rem};
    end
  end

`ifdef DIV_ROUND_UP_SEQ_REMAINDER_EN
  assign remainder = rem[WIDTH-1:0];
`endif

endmodule

// File: tb/tb_div_round_up_seq.sv
// Self-checking bench for div_round_up_seq: directed cases, sweep, random operands,
// backpressure and mid-operation reset, checked against an arithmetic reference.
`timescale 1ns/1ps
module tb_div_round_up_seq;

  localparam int WIDTH = 10;
  localparam int LAT   = WIDTH + 2;
  localparam int ONES  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] dividend = '0;
  logic [WIDTH-1:0] divisor = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] quotient;
  logic             div_by_zero;
`ifdef DIV_ROUND_UP_SEQ_REMAINDER_EN
  logic [WIDTH-1:0] remainder;
`endif

  int checks = 0;
  int errors = 0;

  div_round_up_seq #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
`ifdef DIV_ROUND_UP_SEQ_REMAINDER_EN
    .remainder   (remainder),
`endif
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  function automatic int refQuotient(input int a, input int b);
    if (b == 0) return ONES;
    return (a + b - 1) / b;
  endfunction

  function automatic int refRemainder(input int a, input int b);
    if (b == 0) return 0;
    return a % b;
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One full operation; hold > 0 keeps out_ready low that many cycles in DONE first.
  task automatic applyStimulus(input int a, input int b, input int hold);
    int waitCycles;
    int edges;
    string op;
    op = $sformatf("%0d/%0d", a, b);
    waitCycles = 0;
    while (!in_ready && waitCycles < 3 * LAT) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    checkOutput({"in_ready before accept ", op}, int'(in_ready), 1);
    in_valid = 1'b1;
    dividend = WIDTH'(a);
    divisor  = WIDTH'(b);
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = WIDTH'($urandom_range(0, ONES));
    divisor  = WIDTH'($urandom_range(0, ONES));
    edges = 0;
    while (!out_valid && edges < 3 * LAT) begin
      @(posedge clk); #1;
      edges++;
    end
    checkOutput({"latency ", op}, edges, (b == 0) ? 0 : LAT);
    checkOutput({"quotient ", op}, int'(quotient), refQuotient(a, b));
    checkOutput({"div_by_zero ", op}, int'(div_by_zero), (b == 0) ? 1 : 0);
`ifdef DIV_ROUND_UP_SEQ_REMAINDER_EN
    checkOutput({"remainder ", op}, int'(remainder), refRemainder(a, b));
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checkOutput({"held quotient ", op}, int'(quotient), refQuotient(a, b));
      checkOutput({"held div_by_zero ", op}, int'(div_by_zero), (b == 0) ? 1 : 0);
      checkOutput({"held out_valid ", op}, int'(out_valid), 1);
      checkOutput({"held in_ready ", op}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({"in_ready after handshake ", op}, int'(in_ready), 1);
    checkOutput({"out_valid after handshake ", op}, int'(out_valid), 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset in_ready", int'(in_ready), 1);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset quotient", int'(quotient), 0);
    checkOutput("reset div_by_zero", int'(div_by_zero), 0);
`ifdef DIV_ROUND_UP_SEQ_REMAINDER_EN
    checkOutput("reset remainder", int'(remainder), 0);
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    applyStimulus(600, 18, 0);
    applyStimulus(540, 18, 0);
    applyStimulus(0, 10, 0);
    applyStimulus(1023, 1, 0);
    applyStimulus(5, 7, 0);
    applyStimulus(7, 0, 0);
    applyStimulus(1023, 1023, 0);
    applyStimulus(1, 1023, 0);
    applyStimulus(600, 18, 20);
    applyStimulus(7, 0, 5);

    for (int a = 0; a <= 600; a++) begin
      applyStimulus(a, 1, 0);
      applyStimulus(a, 10, 0);
      applyStimulus(a, 18, 0);
    end

    for (int n = 0; n < 200; n++) begin
      int a;
      int b;
      a = $urandom_range(0, ONES);
      case ($urandom_range(0, 3))
        0:       b = 0;
        1:       b = $urandom_range(1, 16);
        default: b = $urandom_range(1, ONES);
      endcase
      applyStimulus(a, b, $urandom_range(0, 2));
    end

    // Abort an operation partway through CALC.
    in_valid = 1'b1;
    dividend = WIDTH'(500);
    divisor  = WIDTH'(7);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid-op reset out_valid", int'(out_valid), 0);
    checkOutput("mid-op reset in_ready", int'(in_ready), 1);
    checkOutput("mid-op reset quotient", int'(quotient), 0);
    checkOutput("mid-op reset div_by_zero", int'(div_by_zero), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(100, 10, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
